filtro_secuenciador: RTL and testbench

// - Control FSM for the 27-bit fixed-point IIR filter datapath. Turns each datolisto

---
 rtl/filtro_ctrl_pkg.sv | 40 ++++
 rtl/sec_phase_timer.sv | 23 ++
 rtl/filtro_secuenciador.sv | 133 +++++++++++++
 tb/tb_filtro_secuenciador.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_ctrl_pkg.sv
// Shared constants, state encoding and decode helpers for the IIR filter sequencer.
package filtro_ctrl_pkg;

  localparam int unsigned NUM_PHASES = 7;
  localparam int unsigned NUM_COEF   = 5;
  localparam int unsigned COEF_SEL_W = 3;
  localparam int unsigned STEP_CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PH1  = 4'd1,
    PH2  = 4'd2,
    PH3  = 4'd3,
    PH4  = 4'd4,
    PH5  = 4'd5,
    PH6  = 4'd6,
    PH7  = 4'd7,
    DONE = 4'd8
  } state_t;

  function automatic logic is_phase(input state_t s);
    return (s >= PH1) && (s <= PH7);
  endfunction

  // Coefficient index used by the shared multiplier in PH2..PH6
  function automatic logic [COEF_SEL_W-1:0] coef_of(input state_t s);
    logic [COEF_SEL_W-1:0] sel;
    sel = '0;
    case (s)
      PH2: sel = COEF_SEL_W'(0);
      PH3: sel = COEF_SEL_W'(1);
      PH4: sel = COEF_SEL_W'(2);
      PH5: sel = COEF_SEL_W'(3);
      PH6: sel = COEF_SEL_W'(4);
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sec_phase_timer.sv
// Per-phase step counter; last_step marks the final cycle of the current phase.
module sec_phase_timer
  import filtro_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic                  last_step
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    step_cnt <= '0;
    else if (clr) step_cnt <= '0;
    else if (inc) step_cnt <= step_cnt + STEP_CNT_W'(1);
  end

  assign last_step = (step_cnt == STEP_CNT_W'(STEP_CYCLES - 1));

endmodule

// File: rtl/filtro_secuenciador.sv
// Seven-phase enable sequencer for the fixed-point IIR datapath, with overrun detection.
// Optional OVERRUN_CNT_EN adds a saturating dropped-sample counter (overrun_cnt).
module filtro_secuenciador
  import filtro_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  datolisto,
  input  logic                  clr_overrun,
  output logic                  en1,
  output logic                  en2,
  output logic                  en3,
  output logic                  en4,
  output logic                  en5,
  output logic                  en6,
  output logic                  en7,
  output logic [COEF_SEL_W-1:0] sel_coef,
  output logic                  busy,
  output logic                  resulisto,
  output logic                  overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt
`endif
);

  state_t                  state_q;
  state_t                  state_d;
  logic                    dl_q;
  logic                    rise;
  logic                    drop;
  logic                    last_step;
  logic [STEP_CNT_W-1:0]   step_cnt;
  logic [NUM_PHASES-1:0]   en_d;
  logic [NUM_PHASES-1:0]   en_q;
  logic [COEF_SEL_W-1:0]   sel_d;
  logic                    busy_d;
  logic                    res_d;

  assign rise = datolisto & ~dl_q;
  assign drop = rise & is_phase(state_q);

  sec_phase_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (~is_phase(state_q) | last_step),
    .inc       (is_phase(state_q)),
    .step_cnt  (step_cnt),
    .last_step (last_step)
  );

  // State register and sample edge register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= datolisto;
    end
  end

  // Next-state logic; a rise in DONE chains straight into the next frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise) state_d = PH1;
      PH1, PH2, PH3, PH4, PH5, PH6, PH7:
        if (last_step) state_d = state_t'(4'(state_q) + 4'd1);
      DONE: state_d = rise ? PH1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    en_d   = '0;
    sel_d  = coef_of(state_d);
    busy_d = (state_d != IDLE);
    res_d  = (state_d == DONE);
    case (state_d)
      PH1: en_d[0] = 1'b1;
      PH2: en_d[1] = 1'b1;
      PH3: en_d[2] = 1'b1;
      PH4: en_d[3] = 1'b1;
      PH5: en_d[4] = 1'b1;
      PH6: en_d[5] = 1'b1;
      PH7: en_d[6] = 1'b1;
      default: en_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      sel_coef  <= '0;
      busy      <= 1'b0;
      resulisto <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      en_q      <= en_d;
      sel_coef  <= sel_d;
      busy      <= busy_d;
      resulisto <= res_d;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign en1 = en_q[0];
  assign en2 = en_q[1];
  assign en3 = en_q[2];
  assign en4 = en_q[3];
  assign en5 = en_q[4];
  assign en6 = en_q[5];
  assign en7 = en_q[6];

`ifdef OVERRUN_CNT_EN
  // Saturating count of dropped samples; a drop in the clear cycle counts as the first
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       overrun_cnt <= '0;
    else if (drop && clr_overrun)    overrun_cnt <= 16'd1;
    else if (drop)                   overrun_cnt <= (overrun_cnt == 16'hFFFF) ? overrun_cnt
                                                                             : overrun_cnt + 16'd1;
    else if (clr_overrun)            overrun_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Scoreboard bench for filtro_secuenciador: STEP_CYCLES=1 and STEP_CYCLES=3 instances.
module tb_filtro_secuenciador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, dl1, clr1, rst3, dl3, clr3;
  logic e1_1, e2_1, e3_1, e4_1, e5_1, e6_1, e7_1, busy1, res1, ovr1;
  logic e1_3, e2_3, e3_3, e4_3, e5_3, e6_3, e7_3, busy3, res3, ovr3;
  logic [2:0] sel1, sel3;
`ifdef OVERRUN_CNT_EN
  logic [15:0] cnt1, cnt3;
`endif

  filtro_secuenciador #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst1), .datolisto(dl1), .clr_overrun(clr1),
    .en1(e1_1), .en2(e2_1), .en3(e3_1), .en4(e4_1), .en5(e5_1), .en6(e6_1), .en7(e7_1),
    .sel_coef(sel1), .busy(busy1), .resulisto(res1), .overrun(ovr1)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(cnt1)
`endif
  );

  filtro_secuenciador #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3), .datolisto(dl3), .clr_overrun(clr3),
    .en1(e1_3), .en2(e2_3), .en3(e3_3), .en4(e4_3), .en5(e5_3), .en6(e6_3), .en7(e7_3),
    .sel_coef(sel3), .busy(busy3), .resulisto(res3), .overrun(ovr3)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(cnt3)
`endif
  );

  // {en7..en1, sel_coef, busy, resulisto, overrun}
  logic [12:0] obs1, obs3;
  assign obs1 = {e7_1, e6_1, e5_1, e4_1, e3_1, e2_1, e1_1, sel1, busy1, res1, ovr1};
  assign obs3 = {e7_3, e6_3, e5_3, e4_3, e3_3, e2_3, e1_3, sel3, busy3, res3, ovr3};

  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Expected {en, sel, busy, resulisto} c cycles after the rise is sampled, step length s
  function automatic logic [11:0] exp_vec(input int c, input int s);
    logic [6:0] en;
    logic [2:0] sel;
    logic       bsy, res;
    int         n;
    en = '0; sel = '0; bsy = 1'b0; res = 1'b0;
    if (c >= 1 && c <= 7*s) begin
      n = (c - 1) / s;
      en[n] = 1'b1;
      if (n >= 1 && n <= 5) sel = 3'(n - 1);
      bsy = 1'b1;
    end else if (c == 7*s + 1) begin
      bsy = 1'b1;
      res = 1'b1;
    end
    return {en, sel, bsy, res};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst1 = 1'b1; rst3 = 1'b1; dl1 = 1'b0; dl3 = 1'b0; clr1 = 1'b0; clr3 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst1 = 1'b0; rst3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL reset_idle_s1 c=%0d got=%h exp=%h", c, obs1, e);
      else n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if (obs3 !== e) $display("FAIL reset_idle_s3 c=%0d got=%h exp=%h", c, obs3, e);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_single_pulse();
    logic [12:0] e;
    for (int c = 0; c <= 10; c++) exp_q.push_back({exp_vec(c, 1), 1'b0});
    for (int c = 0; c <= 10; c++) begin
      dl1 = (c == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL single_pulse c=%0d got=%h exp=%h", c, obs1, e);
      else n_pass++;
      next_cycle();
    end
    dl1 = 1'b0;
  endtask

  task automatic test_held_level();
    logic [12:0] e;
    for (int c = 0; c <= 34; c++) exp_q.push_back({exp_vec(c, 1), 1'b0});
    for (int c = 0; c <= 34; c++) begin
      dl1 = (c < 30);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL held_level c=%0d got=%h exp=%h", c, obs1, e);
      else n_pass++;
      next_cycle();
    end
    dl1 = 1'b0;
  endtask

  task automatic test_overrun();
    logic [12:0] e;
    for (int c = 0; c <= 16; c++) exp_q.push_back({exp_vec(c, 1), (c >= 5 && c <= 12)});
    for (int c = 0; c <= 16; c++) begin
      dl1  = (c == 0 || c == 4);
      clr1 = (c == 12);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL overrun c=%0d got=%h exp=%h", c, obs1, e);
      else n_pass++;
      next_cycle();
    end
    dl1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    for (int c = 0; c <= 20; c++)
      exp_q.push_back({(c <= 8) ? exp_vec(c, 1) : exp_vec(c - 8, 1), 1'b0});
    for (int c = 0; c <= 20; c++) begin
      dl1 = (c == 0 || c == 8);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs1, e);
      else n_pass++;
      next_cycle();
    end
    dl1 = 1'b0;
  endtask

  task automatic test_step3_frame();
    logic [12:0] e;
    for (int c = 0; c <= 25; c++) exp_q.push_back({exp_vec(c, 3), 1'b0});
    for (int c = 0; c <= 25; c++) begin
      dl3 = (c == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs3 !== e) $display("FAIL step3_frame c=%0d got=%h exp=%h", c, obs3, e);
      else n_pass++;
      next_cycle();
    end
    dl3 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [12:0] e;
    for (int c = 0; c <= 30; c++) exp_q.push_back((c < 10) ? {exp_vec(c, 3), 1'b0} : 13'd0);
    for (int c = 0; c <= 30; c++) begin
      dl3  = (c == 0);
      rst3 = (c == 10);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs3 !== e) $display("FAIL reset_midframe c=%0d got=%h exp=%h", c, obs3, e);
      else n_pass++;
      next_cycle();
    end
    dl3 = 1'b0; rst3 = 1'b0;
  endtask

`ifdef OVERRUN_CNT_EN
  task automatic test_overrun_cnt();
    logic [12:0] e;
    exp_q.push_back(13'd3);
    exp_q.push_back(13'd0);
    for (int c = 0; c <= 14; c++) begin
      dl1  = (c == 0 || c == 2 || c == 4 || c == 6);
      clr1 = (c == 12);
      @(negedge clk);
      if (c == 10 || c == 13) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cnt1 !== e[15-3:0]) $display("FAIL overrun_cnt c=%0d got=%0d exp=%0d", c, cnt1, e);
        else n_pass++;
      end
      next_cycle();
    end
    dl1 = 1'b0; clr1 = 1'b0;
  endtask
`endif

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; dl1 = 1'b0; dl3 = 1'b0; clr1 = 1'b0; clr3 = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_level();
    test_overrun();
    test_back_to_back();
`ifdef OVERRUN_CNT_EN
    test_overrun_cnt();
`endif
    test_step3_frame();
    test_reset_midframe();
    test_step3_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
